// File: rtl/uart_cfg_seq.sv
// uart_cfg_seq: boot-time configuration sequencer and register-port owner for the UART core.
// After reset it writes a fixed six-step programming sequence to the core's 8-bit register
// port. The sequence is: DLAB set, DLL, DLM, LCR (DLAB cleared), FCR, IER. It then hands the
// port to the upstream APB bridge as a zero-latency pass-through. A restart request in DONE
// re-runs the sequence.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   up_*              upstream register access (addr/read/write/wdata in, rdata/err out)
//   reg_*             core register port (addr/read/write/wdata out, rdata/err in)
//   cfg_restart       re-run the sequence (honoured only in DONE)
//   cfg_busy          sequence pending or in progress
//   cfg_done          register port owned by upstream
//   cfg_err           sticky: core flagged an error on a sequence write
module uart_cfg_seq #(
  parameter logic [15:0] DIVISOR = 16'd54,
  parameter logic [7:0]  LCR_VAL = 8'h03,
  parameter logic [7:0]  FCR_VAL = 8'h07,
  parameter logic [7:0]  IER_VAL = 8'h00,
  parameter int unsigned GAP     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] up_addr,
  input  logic       up_read,
  input  logic       up_write,
  input  logic [7:0] up_wdata,
  output logic [7:0] up_rdata,
  output logic       up_err,
  output logic [2:0] reg_addr,
  output logic       reg_read,
  output logic       reg_write,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  input  logic       reg_err,
  input  logic       cfg_restart,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_err
);

  localparam logic [7:0] GapCnt   = 8'(GAP);
  localparam logic [2:0] LastStep = 3'd5;

  typedef enum logic [1:0] {StIdle, StSeq, StGapw, StDone} state_e;

  state_e     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [7:0] gap_q, gap_d;
  logic       err_q, err_d;

  logic [2:0] step_addr;
  logic [7:0] step_data;

  // Programming table; DLAB is left cleared by forcing LCR bit 7 low on the final LCR write.
  always_comb begin
    step_addr = 3'd0;
    step_data = 8'h00;
    case (step_q)
      3'd0: begin step_addr = 3'd3; step_data = 8'h80;                end
      3'd1: begin step_addr = 3'd0; step_data = DIVISOR[7:0];         end
      3'd2: begin step_addr = 3'd1; step_data = DIVISOR[15:8];        end
      3'd3: begin step_addr = 3'd3; step_data = {1'b0, LCR_VAL[6:0]}; end
      3'd4: begin step_addr = 3'd2; step_data = FCR_VAL;              end
      3'd5: begin step_addr = 3'd1; step_data = IER_VAL;              end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    gap_d     = gap_q;
    err_d     = err_q;
    reg_addr  = 3'd0;
    reg_read  = 1'b0;
    reg_write = 1'b0;
    reg_wdata = 8'h00;
    up_rdata  = 8'h00;
    up_err    = 1'b0;

    unique case (state_q)
      StIdle: begin
        up_err  = 1'b1;
        step_d  = 3'd0;
        state_d = StSeq;
      end
      StSeq: begin
        reg_write = 1'b1;
        reg_addr  = step_addr;
        reg_wdata = step_data;
        up_err    = up_read | up_write;
        if (reg_err) err_d = 1'b1;
        if (step_q == LastStep) begin
          state_d = StDone;
        end else begin
          step_d = step_q + 3'd1;
          if (GAP != 0) begin
            gap_d   = GapCnt;
            state_d = StGapw;
          end
        end
      end
      StGapw: begin
        up_err = up_read | up_write;
        gap_d  = gap_q - 8'd1;
        if (gap_q == 8'd1) state_d = StSeq;
      end
      StDone: begin
        // Pass-through stays live in the restart cycle so an overlapping access completes.
        reg_addr  = up_addr;
        reg_read  = up_read;
        reg_write = up_write;
        reg_wdata = up_wdata;
        up_rdata  = reg_rdata;
        up_err    = reg_err;
        if (cfg_restart) begin
          err_d   = 1'b0;
          step_d  = 3'd0;
          state_d = StSeq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      step_q  <= 3'd0;
      gap_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end

  assign cfg_busy = (state_q != StDone);
  assign cfg_done = (state_q == StDone);
  assign cfg_err  = err_q;

endmodule
